hamming_secded_stream_encoder: RTL and testbench

//  Streaming Hamming encoder, parametrised in data width, with optional SECDED overall-parity bit.

---
 rtl/hamming_secded_stream_encoder.sv | 119 +++++++++++
 tb/tb_hamming_secded_stream_encoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_stream_encoder.sv
// Streaming Hamming / SECDED encoder with a main + skid output buffer,
// per-word single-bit error injection and a wrapping count of delivered words.
module hamming_secded_stream_encoder #(
    parameter int DATA_W = 16,
    parameter int SECDED = 1,
    localparam int P     = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6,
    localparam int HW    = DATA_W + P,
    localparam int CW    = HW + ((SECDED != 0) ? 1 : 0),
    localparam int POS_W = $clog2(CW)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [POS_W-1:0]  inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_code,
    output logic [15:0]       word_count
);

    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0]     c;
        logic [CW-1:0]     m;
        logic [CW-1:0]     par;
        logic [DATA_W-1:0] d_sh;
        c    = '0;
        par  = '0;
        d_sh = d;
        // Data bits occupy the non-power-of-two positions in ascending order.
        for (int k = 1; k <= HW; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (d_sh[0]) c = c | (CW'(1) << (k - 1));
                d_sh = d_sh >> 1;
            end
        end
        for (int j = 0; j < P; j++) begin
            m = '0;
            for (int k = 1; k <= HW; k++) begin
                if (((k >> j) & 1) != 0) m = m | (CW'(1) << (k - 1));
            end
            if (^(c & m)) par = par | (CW'(1) << ((1 << j) - 1));
        end
        c = c | par;
        if (SECDED != 0) c = c | (CW'(^c) << (CW - 1));
        return c;
    endfunction

    function automatic logic [CW-1:0] inject(input logic [CW-1:0] c,
                                             input logic en,
                                             input logic [POS_W-1:0] pos);
        logic [CW-1:0] r;
        r = c;
        if (en && (32'(pos) < CW)) r = c ^ (CW'(1) << pos);
        return r;
    endfunction

    logic [CW-1:0] enc_p0;
    logic [CW-1:0] main_code_p1;
    logic [CW-1:0] skid_code_p1;
    logic          vld_p1;
    logic          skid_vld_p1;
    logic          skid_vld_nxt;
    logic          rdy_q;
    logic [15:0]   count_p1;
    logic          in_xfer;
    logic          out_xfer;

    // Stage p0: combinational encode + injection of the presented word.
    assign enc_p0   = inject(encode(in_data), inj_en, inj_pos);
    assign in_xfer  = in_valid && rdy_q;
    assign out_xfer = vld_p1 && out_ready;

    always_comb begin
        skid_vld_nxt = skid_vld_p1;
        if (skid_vld_p1) begin
            if (out_xfer) skid_vld_nxt = 1'b0;
        end else if (in_xfer && vld_p1 && !out_xfer) begin
            skid_vld_nxt = 1'b1;
        end
    end

    // Stage p1: main (output) register and skid register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1       <= 1'b0;
            skid_vld_p1  <= 1'b0;
            rdy_q        <= 1'b0;
            main_code_p1 <= '0;
            count_p1     <= '0;
        end else begin
            skid_vld_p1 <= skid_vld_nxt;
            rdy_q       <= !skid_vld_nxt;
            if (out_xfer) count_p1 <= count_p1 + 16'd1;
            if (skid_vld_p1) begin
                if (out_xfer) main_code_p1 <= skid_code_p1;
            end else if (in_xfer && (!vld_p1 || out_xfer)) begin
                main_code_p1 <= enc_p0;
                vld_p1       <= 1'b1;
            end else if (out_xfer) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!skid_vld_p1 && in_xfer && vld_p1 && !out_xfer) skid_code_p1 <= enc_p0;
    end

    assign in_ready   = rdy_q;
    assign out_valid  = vld_p1;
    assign out_code   = main_code_p1;
    assign word_count = count_p1;

endmodule

// File: tb/tb_hamming_secded_stream_encoder.sv
// Bench for hamming_secded_stream_encoder: directed vectors on a 16-bit SECDED
// instance plus randomized stall sweeps on 8-bit plain and 32-bit SECDED instances.
module tb_hamming_secded_stream_encoder;

    typedef struct {
        logic [63:0] code;
        int          syn;
        bit          par;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_inj_en, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_word_count;
    logic [4:0]  a_inj_pos;
    logic [21:0] a_out_code;

    logic        b_in_valid, b_in_ready, b_inj_en, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data;
    logic [15:0] b_word_count;
    logic [3:0]  b_inj_pos;
    logic [11:0] b_out_code;

    logic        c_in_valid, c_in_ready, c_inj_en, c_out_valid, c_out_ready;
    logic [31:0] c_in_data;
    logic [15:0] c_word_count;
    logic [5:0]  c_inj_pos;
    logic [38:0] c_out_code;

    hamming_secded_stream_encoder #(.DATA_W(16), .SECDED(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .inj_en(a_inj_en), .inj_pos(a_inj_pos), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_code(a_out_code), .word_count(a_word_count));

    hamming_secded_stream_encoder #(.DATA_W(8), .SECDED(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .inj_en(b_inj_en), .inj_pos(b_inj_pos), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_code(b_out_code), .word_count(b_word_count));

    hamming_secded_stream_encoder #(.DATA_W(32), .SECDED(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .inj_en(c_inj_en), .inj_pos(c_inj_pos), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_code(c_out_code), .word_count(c_word_count));

    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    // Reference encoder: the XOR of the positions of all set data bits directly
    // gives the parity bits (bit j of that XOR is the parity at position 2^j).
    function automatic logic [63:0] ref_encode(input int dw, input bit secded,
                                               input logic [63:0] d, input bit inj, input int pos);
        int          p;
        int          hw;
        int          cw;
        int          di;
        int          s;
        logic [63:0] c;
        p  = calc_p(dw);
        hw = dw + p;
        cw = hw + (secded ? 1 : 0);
        di = 0;
        s  = 0;
        c  = '0;
        for (int k = 1; k <= hw; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (((d >> di) & 64'd1) != 64'd0) begin
                    c = c | (64'd1 << (k - 1));
                    s = s ^ k;
                end
                di++;
            end
        end
        for (int j = 0; j < p; j++) begin
            if (((s >> j) & 1) != 0) c = c | (64'd1 << ((1 << j) - 1));
        end
        if (secded && (^c)) c = c | (64'd1 << hw);
        if (inj && pos < cw) c = c ^ (64'd1 << pos);
        return c;
    endfunction

    function automatic int ref_syndrome(input int hw, input logic [63:0] c);
        int s;
        s = 0;
        for (int k = 1; k <= hw; k++) begin
            if (((c >> (k - 1)) & 64'd1) != 64'd0) s = s ^ k;
        end
        return s;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        nvec++; if (a_in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
        nvec++; if (a_out_code !== 22'h0) begin nerr++; $display("FAIL reset_out_code: got %h expected 000000", a_out_code); end
        nvec++; if (a_word_count !== 16'h0) begin nerr++; $display("FAIL reset_word_count: got %h expected 0000", a_word_count); end
        reset_n = 1'b1;
        @(negedge clk);
        nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_in_ready: got %b expected 1", a_in_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0] dv [3];
        logic [21:0] ev [3];
        dv = '{16'h0000, 16'h0001, 16'hFFFF};
        ev = '{22'h000000, 22'h200007, 22'h1FFFFE};
        a_out_ready = 1'b1;
        a_inj_en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, a_in_ready); end
            a_in_valid = 1'b1;
            a_in_data  = dv[i];
            @(negedge clk);
            a_in_valid = 1'b0;
            nvec++; if (a_out_valid !== 1'b1) begin nerr++; $display("FAIL vec%0d_out_valid: got %b expected 1", i, a_out_valid); end
            nvec++; if (a_out_code !== ev[i]) begin nerr++; $display("FAIL vec%0d_code: got %h expected %h", i, a_out_code, ev[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_injection();
        int          pv [3];
        logic [21:0] ev [3];
        pv = '{0, 21, 31};
        ev = '{22'h200006, 22'h000007, 22'h200007};
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'h0001;
            a_inj_en   = 1'b1;
            a_inj_pos  = 5'(pv[i]);
            @(negedge clk);
            a_in_valid = 1'b0;
            a_inj_en   = 1'b0;
            nvec++; if (a_out_code !== ev[i]) begin nerr++; $display("FAIL inj_pos%0d_code: got %h expected %h", pv[i], a_out_code, ev[i]); end
            @(negedge clk);
        end
        nvec++; if (a_word_count !== 16'd6) begin nerr++; $display("FAIL inj_word_count: got %0d expected 6", a_word_count); end
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL inj_idle_out_valid: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [3];
        logic [21:0] e [3];
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            e[i] = 22'(ref_encode(16, 1'b1, 64'(w[i]), 1'b0, 0));
        end
        a_out_ready = 1'b0;
        a_inj_en    = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = w[0];
        @(negedge clk);
        nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_first: got %b expected 1", a_in_ready); end
        nvec++; if (a_out_code !== e[0]) begin nerr++; $display("FAIL bp_first_code: got %h expected %h", a_out_code, e[0]); end
        a_in_data = w[1];
        @(negedge clk);
        nvec++; if (a_in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_after_second: got %b expected 0", a_in_ready); end
        a_in_data = w[2];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if (a_in_ready !== 1'b0) begin nerr++; $display("FAIL bp_stall%0d_ready: got %b expected 0", i, a_in_ready); end
            nvec++; if (a_out_valid !== 1'b1 || a_out_code !== e[0]) begin
                nerr++; $display("FAIL bp_stall%0d_hold: got %b/%h expected 1/%h", i, a_out_valid, a_out_code, e[0]);
            end
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        nvec++; if (a_out_code !== e[1]) begin nerr++; $display("FAIL bp_second_code: got %h expected %h", a_out_code, e[1]); end
        nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_rise: got %b expected 1", a_in_ready); end
        @(negedge clk);
        a_in_valid = 1'b0;
        nvec++; if (a_out_valid !== 1'b1 || a_out_code !== e[2]) begin
            nerr++; $display("FAIL bp_third_code: got %b/%h expected 1/%h", a_out_valid, a_out_code, e[2]);
        end
        @(negedge clk);
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drained: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d [100];
        logic [21:0] exp_code;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) d[i] = 16'($urandom);
        a_out_ready = 1'b1;
        a_inj_en    = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = d[0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            exp_code = 22'(ref_encode(16, 1'b1, 64'(d[i]), 1'b0, 0));
            nvec++; if (a_out_valid !== 1'b1 || a_out_code !== exp_code) begin
                nerr++; $display("FAIL b2b_word%0d: got %b/%h expected 1/%h", i, a_out_valid, a_out_code, exp_code);
            end
            nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready%0d: got %b expected 1", i, a_in_ready); end
            if (i < 99) a_in_data = d[i + 1];
            else a_in_valid = 1'b0;
        end
        @(negedge clk);
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drained: got %b expected 0", a_out_valid); end
        nvec++; if (a_word_count !== 16'd100) begin nerr++; $display("FAIL b2b_word_count: got %0d expected 100", a_word_count); end
    endtask

    task automatic test_reset_midflight();
        a_out_ready = 1'b0;
        a_inj_en    = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'($urandom);
        @(negedge clk);
        a_in_data = 16'($urandom);
        @(negedge clk);
        a_in_valid = 1'b0;
        nvec++; if (a_in_ready !== 1'b0) begin nerr++; $display("FAIL mid_full_ready: got %b expected 0", a_in_ready); end
        reset_n = 1'b0;
        @(negedge clk);
        nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL mid_reset_out_valid: got %b expected 0", a_out_valid); end
        nvec++; if (a_word_count !== 16'd0) begin nerr++; $display("FAIL mid_reset_word_count: got %0d expected 0", a_word_count); end
        nvec++; if (a_out_code !== 22'h0) begin nerr++; $display("FAIL mid_reset_out_code: got %h expected 000000", a_out_code); end
        reset_n     = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL mid_stale%0d: got out_valid %b expected 0", i, a_out_valid); end
        end
        nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready_after: got %b expected 1", a_in_ready); end
    endtask

    task automatic test_sweep8();
        exp_t        q [$];
        exp_t        e;
        logic [15:0] wc;
        logic [11:0] held_code;
        bit          held;
        int          syn;
        int          pos;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        dut_b.count_p1 = 16'hFFF0;
        wc   = 16'hFFF0;
        held = 1'b0;
        for (int cyc = 0; cyc < 604; cyc++) begin
            @(negedge clk);
            if (held) begin
                nvec++; if (b_out_valid !== 1'b1 || b_out_code !== held_code) begin
                    nerr++; $display("FAIL s8_hold: got %b/%h expected 1/%h", b_out_valid, b_out_code, held_code);
                end
            end
            b_out_ready = (cyc >= 600) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (b_out_valid && b_out_ready) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++; $display("FAIL s8_spurious: got %h expected no word", b_out_code);
                end else begin
                    e = q.pop_front();
                    if (b_out_code !== e.code[11:0]) begin
                        nerr++; $display("FAIL s8_code: got %h expected %h", b_out_code, e.code[11:0]);
                    end
                    syn = ref_syndrome(12, 64'(b_out_code));
                    nvec++; if (syn != e.syn) begin nerr++; $display("FAIL s8_syndrome: got %0d expected %0d", syn, e.syn); end
                end
                wc = wc + 16'd1;
            end
            held      = b_out_valid && !b_out_ready;
            held_code = b_out_code;
            b_in_valid = (cyc < 600) && ($urandom_range(0, 3) != 0);
            b_in_data  = 8'($urandom);
            b_inj_en   = ($urandom_range(0, 3) == 0);
            b_inj_pos  = 4'($urandom);
            if (b_in_valid && b_in_ready) begin
                pos    = int'(b_inj_pos);
                e.code = ref_encode(8, 1'b0, 64'(b_in_data), b_inj_en, pos);
                e.syn  = (b_inj_en && pos < 12) ? pos + 1 : 0;
                e.par  = 1'b0;
                q.push_back(e);
            end
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL s8_undelivered: got %0d left expected 0", q.size()); end
        nvec++; if (b_word_count !== wc) begin nerr++; $display("FAIL s8_wrap_count: got %h expected %h", b_word_count, wc); end
    endtask

    task automatic test_sweep32();
        exp_t        q [$];
        exp_t        e;
        logic [15:0] wc;
        logic [38:0] held_code;
        bit          held;
        int          syn;
        int          pos;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        dut_c.count_p1 = 16'hFFE0;
        wc   = 16'hFFE0;
        held = 1'b0;
        for (int cyc = 0; cyc < 604; cyc++) begin
            @(negedge clk);
            if (held) begin
                nvec++; if (c_out_valid !== 1'b1 || c_out_code !== held_code) begin
                    nerr++; $display("FAIL s32_hold: got %b/%h expected 1/%h", c_out_valid, c_out_code, held_code);
                end
            end
            c_out_ready = (cyc >= 600) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (c_out_valid && c_out_ready) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++; $display("FAIL s32_spurious: got %h expected no word", c_out_code);
                end else begin
                    e = q.pop_front();
                    if (c_out_code !== e.code[38:0]) begin
                        nerr++; $display("FAIL s32_code: got %h expected %h", c_out_code, e.code[38:0]);
                    end
                    syn = ref_syndrome(38, 64'(c_out_code));
                    nvec++; if (syn != e.syn) begin nerr++; $display("FAIL s32_syndrome: got %0d expected %0d", syn, e.syn); end
                    nvec++; if ((^c_out_code) !== e.par) begin nerr++; $display("FAIL s32_overall: got %b expected %b", ^c_out_code, e.par); end
                end
                wc = wc + 16'd1;
            end
            held      = c_out_valid && !c_out_ready;
            held_code = c_out_code;
            c_in_valid = (cyc < 600) && ($urandom_range(0, 3) != 0);
            c_in_data  = $urandom;
            c_inj_en   = ($urandom_range(0, 3) == 0);
            c_inj_pos  = 6'($urandom);
            if (c_in_valid && c_in_ready) begin
                pos    = int'(c_inj_pos);
                e.code = ref_encode(32, 1'b1, 64'(c_in_data), c_inj_en, pos);
                e.syn  = (c_inj_en && pos < 38) ? pos + 1 : 0;
                e.par  = c_inj_en && pos < 39;
                q.push_back(e);
            end
        end
        c_in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL s32_undelivered: got %0d left expected 0", q.size()); end
        nvec++; if (c_word_count !== wc) begin nerr++; $display("FAIL s32_wrap_count: got %h expected %h", c_word_count, wc); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_inj_en = 1'b0; a_inj_pos = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_inj_en = 1'b0; b_inj_pos = '0; b_out_ready = 1'b0;
        c_in_valid  = 1'b0; c_in_data = '0; c_inj_en = 1'b0; c_inj_pos = '0; c_out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_injection();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_sweep8();
        test_sweep32();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
